// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator
// Description : Per-output round-robin switch allocator with registered grants.
//               Define SA_CREDIT_EN to gate each output on downstream credits.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator #(
    parameter  int INPUT_NUM    = 4,
    parameter  int OUTPUT_NUM   = 4,
    parameter  int BUFFER_DEPTH = 4,
    localparam int SEL_SIZE     = (INPUT_NUM  > 1) ? $clog2(INPUT_NUM)  : 1,
    localparam int PORT_W       = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                request_i   [INPUT_NUM],
    input  logic [PORT_W-1:0]   out_port_i  [INPUT_NUM],
    input  logic                credit_i    [OUTPUT_NUM],
    output logic                grant_o     [INPUT_NUM],
    output logic [SEL_SIZE-1:0] sel_o       [OUTPUT_NUM],
    output logic                valid_sel_o [OUTPUT_NUM]
);

    logic [SEL_SIZE-1:0] r_ptr   [OUTPUT_NUM];
    logic                w_elig  [OUTPUT_NUM];
    logic                w_found [OUTPUT_NUM];
    logic [SEL_SIZE-1:0] w_win   [OUTPUT_NUM];
    logic                w_grant [INPUT_NUM];

    // Scan from the priority pointer; the first eligible requester wins.
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            w_found[o] = 1'b0;
            w_win[o]   = '0;
            for (int j = 0; j < INPUT_NUM; j++) begin
                idx = (int'(r_ptr[o]) + j) % INPUT_NUM;
                if (w_elig[o] && !w_found[o] && request_i[idx] &&
                    (int'(out_port_i[idx]) == o)) begin
                    w_found[o] = 1'b1;
                    w_win[o]   = SEL_SIZE'(idx);
                end
            end
        end
    end

    // Each input targets a single output, so one grant per input is implicit.
    always_comb begin
        for (int i = 0; i < INPUT_NUM; i++) begin
            w_grant[i] = 1'b0;
        end
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            if (w_found[o]) begin
                w_grant[w_win[o]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < INPUT_NUM; i++) begin
                grant_o[i] <= 1'b0;
            end
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                sel_o[o]       <= '0;
                valid_sel_o[o] <= 1'b0;
                r_ptr[o]       <= '0;
            end
        end else begin
            for (int i = 0; i < INPUT_NUM; i++) begin
                grant_o[i] <= w_grant[i];
            end
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                sel_o[o]       <= w_win[o];
                valid_sel_o[o] <= w_found[o];
                if (w_found[o]) begin
                    r_ptr[o] <= SEL_SIZE'((int'(w_win[o]) + 1) % INPUT_NUM);
                end
            end
        end
    end

`ifdef SA_CREDIT_EN
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

    logic [CNT_W-1:0] r_cnt [OUTPUT_NUM];

    always_comb begin
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            w_elig[o] = (r_cnt[o] != '0);
        end
    end

    // A grant and a returning credit in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                r_cnt[o] <= CNT_W'(BUFFER_DEPTH);
            end
        end else begin
            for (int o = 0; o < OUTPUT_NUM; o++) begin
                if (w_found[o] && !credit_i[o]) begin
                    r_cnt[o] <= r_cnt[o] - CNT_W'(1);
                end else if (!w_found[o] && credit_i[o] &&
                             (r_cnt[o] < CNT_W'(BUFFER_DEPTH))) begin
                    r_cnt[o] <= r_cnt[o] + CNT_W'(1);
                end
            end
        end
    end
`else
    localparam int unused_buffer_depth = BUFFER_DEPTH;

    logic w_unused_credit;

    always_comb begin
        w_unused_credit = 1'b0;
        for (int o = 0; o < OUTPUT_NUM; o++) begin
            w_elig[o]       = 1'b1;
            w_unused_credit = w_unused_credit ^ credit_i[o];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_allocator
// Description : Directed and random checks of switch_allocator against a
//               behavioural round-robin / credit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int BD = 4;

    logic       clk;
    logic       rst;
    logic       req    [NI];
    logic [1:0] port   [NI];
    logic       credit [NO];
    logic       grant  [NI];
    logic [1:0] sel    [NO];
    logic       vsel   [NO];

    int n_tests;
    int n_fail;

    // Reference model state and the expectation for the most recent edge
    int m_ptr [NO];
    int m_cnt [NO];
    int e_g   [NI];
    int e_s   [NO];
    int e_v   [NO];

    switch_allocator #(
        .INPUT_NUM    (NI),
        .OUTPUT_NUM   (NO),
        .BUFFER_DEPTH (BD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .request_i   (req),
        .out_port_i  (port),
        .credit_i    (credit),
        .grant_o     (grant),
        .sel_o       (sel),
        .valid_sel_o (vsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit model_eligible(input int o);
`ifdef SA_CREDIT_EN
        return m_cnt[o] > 0;
`else
        return 1'b1;
`endif
    endfunction

    // Predict the outcome of the coming edge from the inputs now applied.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) e_g[i] = 0;
        for (int o = 0; o < NO; o++) begin
            e_s[o] = 0;
            e_v[o] = 0;
        end
        if (rst) begin
            for (int o = 0; o < NO; o++) begin
                m_ptr[o] = 0;
                m_cnt[o] = BD;
            end
        end else begin
            for (int o = 0; o < NO; o++) begin
                int best;
                int best_d;
                best   = -1;
                best_d = NI;
                if (model_eligible(o)) begin
                    for (int i = 0; i < NI; i++) begin
                        if (req[i] && int'(port[i]) == o) begin
                            int d;
                            d = (i - m_ptr[o] + NI) % NI;
                            if (d < best_d) begin
                                best   = i;
                                best_d = d;
                            end
                        end
                    end
                end
                if (best >= 0) begin
                    e_g[best] = 1;
                    e_s[o]    = best;
                    e_v[o]    = 1;
                    m_ptr[o]  = (best + 1) % NI;
                end
                if (best >= 0 && !credit[o]) m_cnt[o] = m_cnt[o] - 1;
                else if (best < 0 && credit[o] && m_cnt[o] < BD) m_cnt[o] = m_cnt[o] + 1;
            end
        end
    endtask

    // One clock: predict, advance, then compare every output with the model.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            check_value($sformatf("grant[%0d]", i), int'(grant[i]), e_g[i]);
        for (int o = 0; o < NO; o++) begin
            check_value($sformatf("sel[%0d]", o), int'(sel[o]), e_s[o]);
            check_value($sformatf("valid_sel[%0d]", o), int'(vsel[o]), e_v[o]);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NI; i++) begin
            req[i]  = 1'b0;
            port[i] = 2'd0;
        end
        for (int o = 0; o < NO; o++) credit[o] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int seq [5];
        int cnt_g;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        clear_inputs();
        @(negedge clk);
        do_reset();
        check_value("reset_grant0", int'(grant[0]), 0);
        check_value("reset_valid3", int'(vsel[3]), 0);

        // Single request: input 2 to output 3
        req[2]  = 1'b1;
        port[2] = 2'd3;
        cycle();
        check_value("single_grant2", int'(grant[2]), 1);
        check_value("single_sel3", int'(sel[3]), 2);
        check_value("single_valid3", int'(vsel[3]), 1);
        clear_inputs();
        cycle();

        // Four inputs contend continuously for output 1
        seq = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NI; i++) begin
            req[i]  = 1'b1;
            port[i] = 2'd1;
        end
        credit[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_value($sformatf("rr_sel1_%0d", k), int'(sel[1]), seq[k]);
            check_value($sformatf("rr_grant_%0d", k), int'(grant[seq[k]]), 1);
        end
        clear_inputs();
        cycle();

        // Permutation: every input wins its own output
        req = '{1'b1, 1'b1, 1'b1, 1'b1};
        port[0] = 2'd1;
        port[1] = 2'd0;
        port[2] = 2'd3;
        port[3] = 2'd2;
        cycle();
        for (int i = 0; i < NI; i++)
            check_value($sformatf("perm_grant%0d", i), int'(grant[i]), 1);
        check_value("perm_sel3", int'(sel[3]), 2);
        check_value("perm_sel2", int'(sel[2]), 3);
        check_value("perm_sel1", int'(sel[1]), 0);
        check_value("perm_sel0", int'(sel[0]), 1);
        clear_inputs();
        cycle();

        // Reset lands with continuous requests already applied
        req = '{1'b1, 1'b1, 1'b1, 1'b1};
        port[0] = 2'd0;
        port[1] = 2'd2;
        port[2] = 2'd0;
        port[3] = 2'd2;
        rst = 1'b1;
        cycle();
        check_value("rstreq_grant0", int'(grant[0]), 0);
        check_value("rstreq_valid0", int'(vsel[0]), 0);
        rst = 1'b0;
        cycle();
        check_value("post_rst_sel0", int'(sel[0]), 0);
        check_value("post_rst_sel2", int'(sel[2]), 1);
        check_value("post_rst_grant1", int'(grant[1]), 1);
        clear_inputs();
        cycle();

`ifdef SA_CREDIT_EN
        // Credit exhaustion on output 2 followed by a single credit
        do_reset();
        req[0]  = 1'b1;
        port[0] = 2'd2;
        cnt_g   = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            cnt_g += int'(grant[0]);
        end
        check_value("credit_grants", cnt_g, BD);
        req[0]    = 1'b0;
        credit[2] = 1'b1;
        cycle();
        credit[2] = 1'b0;
        req[0]    = 1'b1;
        cnt_g     = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            cnt_g += int'(grant[0]);
        end
        check_value("credit_refill_grants", cnt_g, 1);
        clear_inputs();
        cycle();
`else
        cnt_g = 0;
`endif

        // Randomized traffic with occasional mid-run resets
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NI; i++) begin
                req[i]  = ($urandom_range(0, 99) < 60);
                port[i] = 2'($urandom_range(0, NO - 1));
            end
            for (int o = 0; o < NO; o++) credit[o] = ($urandom_range(0, 99) < 30);
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 1'b0;
        clear_inputs();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
